// File: rtl/layer_1_maxpool_2x2.sv
// layer_1_maxpool_2x2: streaming 2x2 / stride-2 max-pool over an FP32 feature map
// delivered in raster order, one pixel per valid cycle.
//
// Ports:
//   Clk        in   rising-edge clock
//   Rst        in   asynchronous active-low reset
//   data_in    in   FP32 input pixel (raster order)
//   valid_in   in   qualifies data_in; gaps allowed, no backpressure
//   data_out   out  pooled FP32 pixel, held while valid_out is low
//   valid_out  out  one-cycle pulse qualifying data_out
//   frame_done out  one-cycle pulse with the last pooled pixel of a frame
module layer_1_maxpool_2x2 #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IMG_SIZE   = 416
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  frame_done
);

    localparam int unsigned CW   = (IMG_SIZE > 2) ? $clog2(IMG_SIZE) : 1;
    localparam int unsigned HALF = IMG_SIZE / 2;
    localparam int unsigned AW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(IMG_SIZE - 1);

    typedef enum logic {
        EVEN_ROW = 1'b0,
        ODD_ROW  = 1'b1
    } phase_e;

    // Order-preserving unsigned key of an FP pattern: negatives inverted, positives get MSB set.
    function automatic logic [DATA_WIDTH-1:0] fkey(input logic [DATA_WIDTH-1:0] x);
        fkey = x[DATA_WIDTH-1] ? ~x : {1'b1, x[DATA_WIDTH-2:0]};
    endfunction

    // Max of two samples; 'a' is the earlier operand and wins on equal keys.
    function automatic logic [DATA_WIDTH-1:0] fmax(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
        fmax = (fkey(b) > fkey(a)) ? b : a;
    endfunction

    phase_e                phase_q, phase_d;
    logic [CW-1:0]         col_q, col_d;
    logic [CW-1:0]         row_q, row_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_out_q, valid_out_d;
    logic                  frame_done_q, frame_done_d;

    logic [DATA_WIDTH-1:0] pair_q;
    logic [DATA_WIDTH-1:0] lbuf_q [HALF];

    logic                  col_odd_c;
    logic                  col_last_c;
    logic                  row_last_c;
    logic [AW-1:0]         lb_addr_c;
    logic [DATA_WIDTH-1:0] pair_max_c;
    logic [DATA_WIDTH-1:0] win_max_c;

    assign col_odd_c  = col_q[0];
    assign col_last_c = (col_q == LAST);
    assign row_last_c = (row_q == LAST);
    assign lb_addr_c  = AW'(col_q >> 1);
    assign pair_max_c = fmax(pair_q, data_in);
    // Upper-row result from the line buffer is the earlier operand.
    assign win_max_c  = fmax(lbuf_q[lb_addr_c], pair_max_c);

    // Counters, phase and output registers.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            phase_q      <= EVEN_ROW;
            col_q        <= '0;
            row_q        <= '0;
            data_out_q   <= '0;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            col_q        <= col_d;
            row_q        <= row_d;
            data_out_q   <= data_out_d;
            valid_out_q  <= valid_out_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state: raster walk, phase toggle on row change, pooled output in odd rows.
    always_comb begin
        phase_d      = phase_q;
        col_d        = col_q;
        row_d        = row_q;
        data_out_d   = data_out_q;
        valid_out_d  = 1'b0;
        frame_done_d = 1'b0;
        if (valid_in) begin
            if (col_last_c) begin
                col_d   = '0;
                row_d   = row_last_c ? '0 : row_q + CW'(1);
                // IMG_SIZE is even, so the frame wrap also lands back in EVEN_ROW.
                phase_d = (phase_q == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
            end else begin
                col_d = col_q + CW'(1);
            end
            if ((phase_q == ODD_ROW) && col_odd_c) begin
                data_out_d   = win_max_c;
                valid_out_d  = 1'b1;
                frame_done_d = row_last_c && col_last_c;
            end
        end
    end

    // Pair register and line buffer: datapath storage, intentionally not reset.
    always_ff @(posedge Clk) begin
        if (valid_in) begin
            if (!col_odd_c) begin
                pair_q <= data_in;
            end else if (phase_q == EVEN_ROW) begin
                lbuf_q[lb_addr_c] <= pair_max_c;
            end
        end
    end

    assign data_out   = data_out_q;
    assign valid_out  = valid_out_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_layer_1_maxpool_2x2.sv
// Bench for layer_1_maxpool_2x2: a 4x4 instance for functional scenarios and a
// 64x64 instance for back-to-back frame streaming, checked through scoreboards.
module tb_layer_1_maxpool_2x2;

    localparam int unsigned DW  = 32;
    localparam int unsigned S4  = 4;
    localparam int unsigned S64 = 64;

    logic Clk;
    logic Rst;
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic [DW-1:0] din4, dout4, din64, dout64;
    logic          vin4, vout4, fd4, vin64, vout64, fd64;

    layer_1_maxpool_2x2 #(.DATA_WIDTH(DW), .IMG_SIZE(S4)) dut4 (
        .Clk(Clk), .Rst(Rst), .data_in(din4), .valid_in(vin4),
        .data_out(dout4), .valid_out(vout4), .frame_done(fd4)
    );

    layer_1_maxpool_2x2 #(.DATA_WIDTH(DW), .IMG_SIZE(S64)) dut64 (
        .Clk(Clk), .Rst(Rst), .data_in(din64), .valid_in(vin64),
        .data_out(dout64), .valid_out(vout64), .frame_done(fd64)
    );

    typedef struct {
        logic [31:0] d;
        logic        fd;
        int          cyc;
    } exp_t;

    exp_t        q4[$];
    exp_t        q64[$];
    logic [31:0] got4[$];
    logic [31:0] ramp_ref [4];
    logic [31:0] img4  [S4][S4];
    logic [31:0] img64 [S64][S64];

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   nv64     = 0;
    int   nfd64    = 0;
    logic in_odd4  = 1'b0;

    always @(posedge Clk) cyc <= cyc + 1;

    // Reference float ordering: key compare, earlier operand wins ties.
    function automatic logic [31:0] key(input logic [31:0] x);
        return x[31] ? ~x : {1'b1, x[30:0]};
    endfunction

    function automatic logic [31:0] mx(input logic [31:0] a, input logic [31:0] b);
        return (key(b) > key(a)) ? b : a;
    endfunction

    function automatic logic [31:0] win(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] c, input logic [31:0] d);
        return mx(mx(a, b), mx(c, d));
    endfunction

    // Small non-negative integer to FP32.
    function automatic logic [31:0] i2f(input int n);
        int p;
        if (n == 0) return 32'h0;
        p = 0;
        for (int i = 0; i < 31; i++) if (n[i]) p = i;
        return {1'b0, 8'(127 + p), 23'(n << (23 - p))};
    endfunction

    // Scoreboard, 4x4 instance.
    always @(negedge Clk) begin : mon4
        exp_t e;
        if (vout4 === 1'b1) begin
            got4.push_back(dout4);
            n_checks++;
            if (q4.size() == 0) begin
                $display("FAIL sb4_unexpected: data_out=%h with nothing expected", dout4);
            end else begin
                e = q4.pop_front();
                if (dout4 !== e.d || fd4 !== e.fd || cyc !== e.cyc)
                    $display("FAIL sb4_output: got data=%h fd=%b cyc=%0d, want data=%h fd=%b cyc=%0d",
                             dout4, fd4, cyc, e.d, e.fd, e.cyc);
                else n_pass++;
            end
        end else if (fd4 !== 1'b0) begin
            n_checks++;
            $display("FAIL sb4_fd_alone: frame_done=%b valid_out=%b, want 0", fd4, vout4);
        end
    end

    // Scoreboard, 64x64 instance.
    always @(negedge Clk) begin : mon64
        exp_t e;
        if (vout64 === 1'b1) begin
            nv64++;
            if (fd64 === 1'b1) nfd64++;
            n_checks++;
            if (q64.size() == 0) begin
                $display("FAIL sb64_unexpected: data_out=%h with nothing expected", dout64);
            end else begin
                e = q64.pop_front();
                if (dout64 !== e.d || fd64 !== e.fd || cyc !== e.cyc)
                    $display("FAIL sb64_output: got data=%h fd=%b cyc=%0d, want data=%h fd=%b cyc=%0d",
                             dout64, fd64, cyc, e.d, e.fd, e.cyc);
                else n_pass++;
            end
        end else if (fd64 !== 1'b0) begin
            n_checks++;
            $display("FAIL sb64_fd_alone: frame_done=%b valid_out=%b, want 0", fd64, vout64);
        end
    end

    // A pooled pixel may only follow an odd-row input cycle.
    a_no_even_out: assert property (@(posedge Clk) disable iff (!Rst)
                                    vout4 |-> $past(vin4 && in_odd4))
    else begin
        n_checks++;
        $display("FAIL assert_even_row_output: valid_out=1 after non-odd-row input");
    end

    task automatic idle4(input int n);
        repeat (n) begin
            @(negedge Clk);
            vin4 = 1'b0; din4 = $urandom; in_odd4 = 1'b0;
        end
    endtask

    task automatic idle64(input int n);
        repeat (n) begin
            @(negedge Clk);
            vin64 = 1'b0; din64 = $urandom;
        end
    endtask

    // Stream n_px pixels of img4 with random idle gaps of up to max_gap cycles.
    task automatic send_frame4(input int max_gap, input int n_px);
        for (int k = 0; k < n_px; k++) begin
            int r;
            int c;
            r = k / 4;
            c = k % 4;
            repeat ($urandom_range(max_gap, 0)) begin
                @(negedge Clk);
                vin4 = 1'b0; din4 = $urandom; in_odd4 = 1'b0;
            end
            @(negedge Clk);
            din4 = img4[r][c]; vin4 = 1'b1; in_odd4 = 1'(r % 2);
            if ((r % 2 == 1) && (c % 2 == 1))
                q4.push_back('{d: win(img4[r-1][c-1], img4[r-1][c], img4[r][c-1], img4[r][c]),
                               fd: (r == 3 && c == 3), cyc: cyc + 1});
        end
    endtask

    task automatic send_frame64();
        for (int k = 0; k < int'(S64 * S64); k++) begin
            int r;
            int c;
            r = k / int'(S64);
            c = k % int'(S64);
            @(negedge Clk);
            din64 = img64[r][c]; vin64 = 1'b1;
            if ((r % 2 == 1) && (c % 2 == 1))
                q64.push_back('{d: win(img64[r-1][c-1], img64[r-1][c], img64[r][c-1], img64[r][c]),
                                fd: (r == int'(S64) - 1 && c == int'(S64) - 1), cyc: cyc + 1});
        end
    endtask

    task automatic fill_ramp4();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) img4[r][c] = i2f(r * 4 + c);
    endtask

    task automatic fill_rand4();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) img4[r][c] = $urandom;
    endtask

    task automatic fill_rand64();
        for (int r = 0; r < int'(S64); r++)
            for (int c = 0; c < int'(S64); c++) img64[r][c] = $urandom;
    endtask

    task automatic test_reset();
        Rst = 1'b1; vin4 = 1'b0; din4 = '0; vin64 = 1'b0; din64 = '0;
        #1 Rst = 1'b0;
        #1;
        n_checks++;
        if ({dout4, vout4, fd4} !== '0)
            $display("FAIL reset4: data_out=%h valid_out=%b frame_done=%b, want all 0", dout4, vout4, fd4);
        else n_pass++;
        n_checks++;
        if ({dout64, vout64, fd64} !== '0)
            $display("FAIL reset64: data_out=%h valid_out=%b frame_done=%b, want all 0", dout64, vout64, fd64);
        else n_pass++;
        repeat (2) @(negedge Clk);
        Rst = 1'b1;
        idle4(2);
    endtask

    task automatic test_ramp();
        logic [31:0] want [4];
        want = '{32'h40A0_0000, 32'h40E0_0000, 32'h4150_0000, 32'h4170_0000};
        fill_ramp4();
        got4.delete();
        send_frame4(0, 16);
        idle4(4);
        n_checks++;
        if (got4.size() !== 4) $display("FAIL ramp_count: got %0d outputs, want 4", got4.size());
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            ramp_ref[i] = (i < got4.size()) ? got4[i] : 32'hxxxx_xxxx;
            n_checks++;
            if (ramp_ref[i] !== want[i]) $display("FAIL ramp_value[%0d]: got %h, want %h", i, ramp_ref[i], want[i]);
            else n_pass++;
        end
        n_checks++;
        if (dout4 !== 32'h4170_0000 || vout4 !== 1'b0)
            $display("FAIL ramp_hold: data_out=%h valid_out=%b, want 41700000 and 0", dout4, vout4);
        else n_pass++;
        n_checks++;
        if (q4.size() !== 0) $display("FAIL ramp_drain: %0d expected outputs missing, want 0", q4.size());
        else n_pass++;
    endtask

    task automatic test_gaps();
        fill_ramp4();
        got4.delete();
        send_frame4(3, 16);
        idle4(4);
        n_checks++;
        if (got4.size() !== 4) $display("FAIL gaps_count: got %0d outputs, want 4", got4.size());
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] g;
            g = (i < got4.size()) ? got4[i] : 32'hxxxx_xxxx;
            n_checks++;
            if (g !== ramp_ref[i]) $display("FAIL gaps_value[%0d]: got %h, want %h", i, g, ramp_ref[i]);
            else n_pass++;
        end
    endtask

    task automatic test_mixed_sign();
        logic [31:0] want [3];
        want = '{32'hBF00_0000, 32'h0000_0000, 32'h4000_0000};
        fill_rand4();
        img4[0][0] = 32'hBF80_0000; img4[0][1] = 32'hC040_0000;
        img4[1][0] = 32'hBF00_0000; img4[1][1] = 32'hC000_0000;
        img4[0][2] = 32'h8000_0000; img4[0][3] = 32'h0000_0000;
        img4[1][2] = 32'h8000_0000; img4[1][3] = 32'h8000_0000;
        img4[2][0] = 32'h4000_0000; img4[2][1] = 32'h4000_0000;
        img4[3][0] = 32'h4000_0000; img4[3][1] = 32'h4000_0000;
        got4.delete();
        send_frame4(1, 16);
        idle4(4);
        for (int i = 0; i < 3; i++) begin
            logic [31:0] g;
            g = (i < got4.size()) ? got4[i] : 32'hxxxx_xxxx;
            n_checks++;
            if (g !== want[i]) $display("FAIL mixed_value[%0d]: got %h, want %h", i, g, want[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random_frames();
        fill_rand4();
        send_frame4(0, 16);
        fill_rand4();
        send_frame4(0, 16);
        idle4(4);
        n_checks++;
        if (q4.size() !== 0) $display("FAIL random_drain: %0d expected outputs missing, want 0", q4.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        fill_ramp4();
        send_frame4(0, 15);
        #2 Rst = 1'b0;
        #1;
        n_checks++;
        if ({dout4, vout4, fd4} !== '0)
            $display("FAIL midreset_async: data_out=%h valid_out=%b frame_done=%b, want all 0", dout4, vout4, fd4);
        else n_pass++;
        @(negedge Clk);
        vin4 = 1'b0; in_odd4 = 1'b0;
        Rst = 1'b1;
        n_checks++;
        if (q4.size() !== 0) $display("FAIL midreset_pending: %0d outputs still expected, want 0", q4.size());
        else n_pass++;
        q4.delete();
        fill_rand4();
        got4.delete();
        send_frame4(0, 16);
        idle4(4);
        n_checks++;
        if (got4.size() !== 4 || q4.size() !== 0)
            $display("FAIL midreset_frame: got %0d outputs with %0d missing, want 4 and 0", got4.size(), q4.size());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        nv64 = 0; nfd64 = 0;
        fill_rand64();
        send_frame64();
        fill_rand64();
        send_frame64();
        idle64(4);
        n_checks++;
        if (nv64 !== 2 * (S64 / 2) * (S64 / 2))
            $display("FAIL b2b_valid_count: got %0d, want %0d", nv64, 2 * (S64 / 2) * (S64 / 2));
        else n_pass++;
        n_checks++;
        if (nfd64 !== 2) $display("FAIL b2b_frame_done_count: got %0d, want 2", nfd64);
        else n_pass++;
        n_checks++;
        if (q64.size() !== 0) $display("FAIL b2b_drain: %0d expected outputs missing, want 0", q64.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_gaps();
        test_mixed_sign();
        test_random_frames();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
